// File: rtl/dmx_pkg.sv
// Shared types and helpers for the 1-to-8 lane distributor.
package dmx_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int NLANE = 8;

  // Map the number of lanes already filled to the lane that receives the next item.
  function automatic logic [2:0] lane_idx(input logic [3:0] cnt, input logic msb_first);
    return msb_first ? (3'd7 - cnt[2:0]) : cnt[2:0];
  endfunction

endpackage

// File: rtl/dmx_lane_reg.sv
// One W-bit lane of the assembled frame: write-enabled register with sync clear.
module dmx_lane_reg #(
  parameter int W = 1
) (
  input  logic         sys_clk,
  input  logic         resetl,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  // Next lane value: clear wins over write so an ack always empties the frame.
  always_comb begin
    // NOTE: assign the default first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (we) begin
      q_d = d;
    end
  end

  // Lane storage.
  always_ff @(posedge sys_clk or negedge resetl) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!resetl) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dmx8r.sv
// Registered 1-to-8 distributor: steers a stream of W-bit items into eight lanes
// and presents the assembled frame on a valid/ack handshake.
module dmx8r
  import dmx_pkg::*;
#(
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic [W-1:0]       din,
  input  logic               din_vld,
  output logic               din_rdy,
  input  logic               gn,
  input  logic               flush,
  output logic [NLANE*W-1:0] q,
  output logic               q_vld,
  input  logic               q_ack,
  output logic [3:0]         cnt
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             acc;
  logic             clr;
  logic [2:0]       lane;
  logic [NLANE-1:0] we;

  // Ready depends only on state and gate, never on din_vld.
  assign din_rdy = (state_q == FILL) && !gn;
  assign acc     = din_vld && din_rdy;
  assign lane    = lane_idx(cnt_q, MSB_FIRST);
  assign clr     = (state_q == HOLD) && q_ack;

  // One-hot lane write enable for the item accepted this cycle.
  always_comb begin
    we = '0;
    if (acc) begin
      we[lane] = 1'b1;
    end
  end

  // Next-state and fill counter; a gated flush is held off like any other input.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (acc) begin
          cnt_d = cnt_q + 4'd1;
        end
        // Empty frames are never emitted: flush needs at least one item, counting this cycle's.
        if ((cnt_d == 4'(NLANE)) || (flush && !gn && (cnt_d != 4'd0))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (q_ack) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    dmx_lane_reg #(
      .W(W)
    ) u_lane (
      .sys_clk(sys_clk),
      .resetl (resetl),
      .clr    (clr),
      .we     (we[k]),
      .d      (din),
      .q      (q[k*W +: W])
    );
  end

  assign q_vld = (state_q == HOLD);
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_dmx8r.sv
// Scoreboard bench for dmx8r: three instances cover W=1/LSB-first, W=4/LSB-first
// and W=1/MSB-first. Expected frames are queued by the stimulus and popped by a
// monitor whenever an instance raises q_vld.
module tb_dmx8r;

  typedef struct {
    int          inst;
    logic [31:0] q;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetl;
  logic [3:0]  din       [3];
  logic        din_vld   [3];
  logic        gn        [3];
  logic        flush     [3];
  logic        q_ack     [3];
  logic        din_rdy_o [3];
  logic        q_vld_o   [3];
  logic [3:0]  cnt_o     [3];
  logic [31:0] qn        [3];
  logic        prev_vld  [3];
  logic [7:0]  qa, qc;
  logic [31:0] qb;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  assign qn[0] = {24'b0, qa};
  assign qn[1] = qb;
  assign qn[2] = {24'b0, qc};

  dmx8r #(.W(1), .MSB_FIRST(1'b0)) u_a (
    .sys_clk(clk), .resetl(resetl), .din(din[0][0:0]), .din_vld(din_vld[0]),
    .din_rdy(din_rdy_o[0]), .gn(gn[0]), .flush(flush[0]), .q(qa),
    .q_vld(q_vld_o[0]), .q_ack(q_ack[0]), .cnt(cnt_o[0])
  );

  dmx8r #(.W(4), .MSB_FIRST(1'b0)) u_b (
    .sys_clk(clk), .resetl(resetl), .din(din[1]), .din_vld(din_vld[1]),
    .din_rdy(din_rdy_o[1]), .gn(gn[1]), .flush(flush[1]), .q(qb),
    .q_vld(q_vld_o[1]), .q_ack(q_ack[1]), .cnt(cnt_o[1])
  );

  dmx8r #(.W(1), .MSB_FIRST(1'b1)) u_c (
    .sys_clk(clk), .resetl(resetl), .din(din[2][0:0]), .din_vld(din_vld[2]),
    .din_rdy(din_rdy_o[2]), .gn(gn[2]), .flush(flush[2]), .q(qc),
    .q_vld(q_vld_o[2]), .q_ack(q_ack[2]), .cnt(cnt_o[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [31:0] q, input logic [3:0] c);
    exp_t x;
    x.inst = i;
    x.q    = q;
    x.cnt  = c;
    sb.push_back(x);
  endtask

  task automatic send(input int i, input logic [3:0] d, input logic fl);
    din[i]     = d;
    din_vld[i] = 1'b1;
    flush[i]   = fl;
    tick();
    din_vld[i] = 1'b0;
    flush[i]   = 1'b0;
  endtask

  task automatic ack(input int i);
    q_ack[i] = 1'b1;
    tick();
    q_ack[i] = 1'b0;
  endtask

  // Monitor: every rising q_vld must match the oldest queued frame.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (q_vld_o[i] && !prev_vld[i]) begin
        check($sformatf("frame_expected_%0d", i), 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("frame_inst_%0d", i), 32'(i), 32'(e.inst));
          check($sformatf("frame_q_%0d", i), qn[i], e.q);
          check($sformatf("frame_cnt_%0d", i), 32'(cnt_o[i]), 32'(e.cnt));
        end
      end
      prev_vld[i] = q_vld_o[i];
    end
  end

  initial begin
    logic [7:0] bits0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; din_vld[i] = 1'b0; gn[i] = 1'b0; flush[i] = 1'b0;
      q_ack[i] = 1'b0; prev_vld[i] = 1'b0;
    end
    resetl = 1'b0;
    #12;
    check("rst_q", qn[0], 32'h0);
    check("rst_q_vld", 32'(q_vld_o[0]), 32'd0);
    check("rst_cnt", 32'(cnt_o[0]), 32'd0);
    check("rst_din_rdy", 32'(din_rdy_o[0]), 32'd1);
    #10 resetl = 1'b1;
    tick();

    // Full frame, W=1, LSB first: items 1,0,1,1,0,0,1,0 -> 8'b0100_1101.
    bits0 = 8'b0100_1101;
    push(0, 32'h4D, 4'd8);
    for (int k = 0; k < 7; k++) send(0, {3'b0, bits0[k]}, 1'b0);
    check("pre8_q_vld", 32'(q_vld_o[0]), 32'd0);
    check("pre8_cnt", 32'(cnt_o[0]), 32'd7);
    send(0, {3'b0, bits0[7]}, 1'b0);
    check("full_q_vld", 32'(q_vld_o[0]), 32'd1);
    check("full_din_rdy", 32'(din_rdy_o[0]), 32'd0);

    // Back-pressure in HOLD: nothing captured, frame stable.
    din[0] = 4'h0; din_vld[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    din_vld[0] = 1'b0;
    check("bp_q", qn[0], 32'h4D);
    check("bp_cnt", 32'(cnt_o[0]), 32'd8);
    ack(0);
    check("ack_q_vld", 32'(q_vld_o[0]), 32'd0);
    check("ack_cnt", 32'(cnt_o[0]), 32'd0);
    check("ack_q", qn[0], 32'h0);
    check("ack_din_rdy", 32'(din_rdy_o[0]), 32'd1);

    // Next item lands in lane 0; stray ack in FILL is ignored.
    send(0, 4'h1, 1'b0);
    ack(0);
    check("stray_ack_cnt", 32'(cnt_o[0]), 32'd1);
    check("stray_ack_q_vld", 32'(q_vld_o[0]), 32'd0);
    push(0, 32'h01, 4'd1);
    flush[0] = 1'b1; tick(); flush[0] = 1'b0;
    ack(0);

    // W=4 full frame 1..8.
    push(1, 32'h87654321, 4'd8);
    for (int k = 1; k <= 8; k++) send(1, 4'(k), 1'b0);
    ack(1);

    // Partial flush A,B,C.
    send(1, 4'hA, 1'b0); send(1, 4'hB, 1'b0); send(1, 4'hC, 1'b0);
    push(1, 32'h00000CBA, 4'd3);
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    check("pflush_q_vld", 32'(q_vld_o[1]), 32'd1);
    ack(1);

    // Flush with nothing accumulated is ignored.
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    tick();
    check("empty_flush_q_vld", 32'(q_vld_o[1]), 32'd0);

    // Flush coincident with an accepted item.
    send(1, 4'h1, 1'b0); send(1, 4'h2, 1'b0);
    push(1, 32'h00000F21, 4'd3);
    send(1, 4'hF, 1'b1);
    check("coflush_cnt", 32'(cnt_o[1]), 32'd3);
    ack(1);

    // Gate pause, W=1 MSB first.
    send(2, 4'h1, 1'b0);
    gn[2] = 1'b1; din[2] = 4'h1; din_vld[2] = 1'b1;
    tick();
    check("gate_din_rdy", 32'(din_rdy_o[2]), 32'd0);
    for (int k = 0; k < 3; k++) tick();
    check("gate_cnt", 32'(cnt_o[2]), 32'd1);
    gn[2] = 1'b0; din_vld[2] = 1'b0;
    push(2, 32'h80, 4'd8);
    for (int k = 0; k < 7; k++) send(2, 4'h0, 1'b0);
    ack(2);

    // Async reset mid-frame.
    for (int k = 0; k < 5; k++) send(0, 4'h1, 1'b0);
    check("mid_q", qn[0], 32'h1F);
    #3 resetl = 1'b0;
    #1;
    check("async_q", qn[0], 32'h0);
    check("async_cnt", 32'(cnt_o[0]), 32'd0);
    check("async_q_vld", 32'(q_vld_o[0]), 32'd0);
    #2 resetl = 1'b1;
    tick();
    bits0 = 8'b1000_0010;
    push(0, 32'h82, 4'd8);
    for (int k = 0; k < 8; k++) send(0, {3'b0, bits0[k]}, 1'b0);
    ack(0);

    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
